// File: rtl/div_pf_seq.sv
// rtl/div_pf_seq.sv - sequential signed Q4.4 restoring divider (IDLE/CALC/DONE handshake)
// Optional saturation of out-of-range quotients: define DIV_PF_SAT_EN.
module div_pf_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] numerator,
    input  logic [7:0] denominator,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] result,
    output logic       divide_by_zero,
    output logic       overflow
);

`ifdef DIV_PF_SAT_EN
    localparam int QW = 12;
`else
    localparam int QW = 8;
`endif

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q;
    logic [11:0]   dvd_q;
    logic [7:0]    dmag_q;
    logic [6:0]    rem_q;
    logic [QW-2:0] quo_q;
    logic          neg_q;
    logic [7:0]    res_q;
    logic          dbz_q;

    logic [7:0]    nmag_in, dmag_in;
    logic [7:0]    rem_sh, rem_nx;
    logic          q_bit;
    logic [QW-1:0] quo_nx;
    logic [7:0]    res_nx;
    logic          accept, last_iter;

    assign accept    = (state_q == IDLE) && in_valid;
    assign last_iter = (state_q == CALC) && (cnt_q == 4'd11);

    // |numerator << 4| fits 12 bits because |numerator| <= 128.
    assign nmag_in = numerator[7]   ? (8'd0 - numerator)   : numerator;
    assign dmag_in = denominator[7] ? (8'd0 - denominator) : denominator;

`ifdef DIV_PF_SAT_EN
    logic ovf_nx;
`endif

    always_comb begin
        rem_sh = {rem_q, dvd_q[11]};
        q_bit  = (rem_sh >= dmag_q);
        rem_nx = q_bit ? (rem_sh - dmag_q) : rem_sh;
        quo_nx = {quo_q, q_bit};
        res_nx = neg_q ? (8'd0 - quo_nx[7:0]) : quo_nx[7:0];
`ifdef DIV_PF_SAT_EN
        ovf_nx = 1'b0;
        if (!neg_q && (quo_nx > 12'd127)) begin
            res_nx = 8'h7F;
            ovf_nx = 1'b1;
        end else if (neg_q && (quo_nx > 12'd128)) begin
            res_nx = 8'h80;
            ovf_nx = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = (denominator == 8'd0) ? DONE : CALC;
            CALC:    if (cnt_q == 4'd11) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            dvd_q   <= 12'd0;
            dmag_q  <= 8'd0;
            rem_q   <= 7'd0;
            quo_q   <= '0;
            neg_q   <= 1'b0;
            res_q   <= 8'd0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q  <= 4'd0;
                dvd_q  <= {nmag_in, 4'b0000};
                dmag_q <= dmag_in;
                rem_q  <= 7'd0;
                quo_q  <= '0;
                neg_q  <= numerator[7] ^ denominator[7];
                if (denominator == 8'd0) begin
                    res_q <= 8'd0;
                    dbz_q <= 1'b1;
                end
            end else if (state_q == CALC) begin
                cnt_q <= cnt_q + 4'd1;
                dvd_q <= {dvd_q[10:0], 1'b0};
                rem_q <= 7'(rem_nx);
                quo_q <= quo_nx[QW-2:0];
                if (last_iter) begin
                    res_q <= res_nx;
                    dbz_q <= 1'b0;
                end
            end
        end
    end

`ifdef DIV_PF_SAT_EN
    logic ovf_q;
    always_ff @(posedge clk) begin
        if (rst)
            ovf_q <= 1'b0;
        else if (accept && (denominator == 8'd0))
            ovf_q <= 1'b0;
        else if (last_iter)
            ovf_q <= ovf_nx;
    end
    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

    assign in_ready       = (state_q == IDLE);
    assign out_valid      = (state_q == DONE);
    assign result         = res_q;
    assign divide_by_zero = dbz_q;

endmodule

// File: tb/tb_div_pf_seq.sv
// tb/tb_div_pf_seq.sv - self-checking bench for div_pf_seq against an integer-division model
module tb_div_pf_seq;
    logic       clk = 1'b0;
    logic       rst, in_valid, out_ready;
    logic [7:0] numerator, denominator;
    logic       in_ready, out_valid, divide_by_zero, overflow;
    logic [7:0] result;

    int checks = 0;
    int errors = 0;

    div_pf_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .numerator(numerator), .denominator(denominator),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .divide_by_zero(divide_by_zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [7:0] n, input logic [7:0] d,
                                  output logic [7:0] r, output logic dz, output logic ov);
        int nn, dd, q;
        nn = $signed(n);
        dd = $signed(d);
        r = 8'h00; dz = 1'b0; ov = 1'b0;
        if (dd == 0) begin
            dz = 1'b1;
        end else begin
            q = (nn * 16) / dd;
`ifdef DIV_PF_SAT_EN
            if (q > 127)       begin r = 8'h7F; ov = 1'b1; end
            else if (q < -128) begin r = 8'h80; ov = 1'b1; end
            else r = 8'(q);
`else
            r = 8'(q);
`endif
        end
    endfunction

    task automatic run_op(input logic [7:0] n, input logic [7:0] d, output int lat,
                          output logic [7:0] r, output logic dz, output logic ov,
                          output logic hold_ok);
        logic [7:0] prev;
        prev = result;
        hold_ok = 1'b1;
        in_valid = 1'b1; numerator = n; denominator = d;
        @(posedge clk); #1;
        in_valid = 1'b0; numerator = 8'($urandom); denominator = 8'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            if (result !== prev || in_ready !== 1'b0) hold_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        r = result; dz = divide_by_zero; ov = overflow;
    endtask

    task automatic release_out(input int delay);
        repeat (delay) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        int lat; logic [7:0] r; logic dz, ov, hk;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; numerator = 8'h00; denominator = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, result, divide_by_zero, overflow} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got rdy=%b vld=%b res=%h dbz=%b ovf=%b exp rdy=1 vld=0 res=00 dbz=0 ovf=0",
                     in_ready, out_valid, result, divide_by_zero, overflow);
        end
        rst = 1'b0;
        run_op(8'h08, 8'h04, lat, r, dz, ov, hk);
        checks++;
        if (lat !== 13 || r !== 8'h20 || dz !== 1'b0) begin
            errors++;
            $display("FAIL first_accept got lat=%0d res=%h dbz=%b exp lat=13 res=20 dbz=0", lat, r, dz);
        end
        release_out(0);
    endtask

    task automatic test_directed;
        logic [7:0] tn[9], td[9], tr[9];
        logic tz[9], to[9];
        int lat, elat; logic [7:0] r; logic dz, ov, hk;
        tn[0]=8'h08; td[0]=8'h04; tr[0]=8'h20; tz[0]=0; to[0]=0;
        tn[1]=8'hF9; td[1]=8'h03; tr[1]=8'hDB; tz[1]=0; to[1]=0;
        tn[2]=8'h07; td[2]=8'h03; tr[2]=8'h25; tz[2]=0; to[2]=0;
        tn[5]=8'h35; td[5]=8'h00; tr[5]=8'h00; tz[5]=1; to[5]=0;
        tn[6]=8'h80; td[6]=8'h80; tr[6]=8'h10; tz[6]=0; to[6]=0;
        tn[7]=8'h7F; td[7]=8'h80; tr[7]=8'hF1; tz[7]=0; to[7]=0;
        tn[3]=8'h20; td[3]=8'h04; tz[3]=0;
        tn[4]=8'h80; td[4]=8'h01; tz[4]=0;
        tn[8]=8'h7F; td[8]=8'h01; tz[8]=0;
`ifdef DIV_PF_SAT_EN
        tr[3]=8'h7F; to[3]=1; tr[4]=8'h80; to[4]=1; tr[8]=8'h7F; to[8]=1;
`else
        tr[3]=8'h80; to[3]=0; tr[4]=8'h00; to[4]=0; tr[8]=8'hF0; to[8]=0;
`endif
        for (int i = 0; i < 9; i++) begin
            elat = (td[i] == 8'h00) ? 1 : 13;
            run_op(tn[i], td[i], lat, r, dz, ov, hk);
            checks++;
            if (lat !== elat || r !== tr[i] || dz !== tz[i] || ov !== to[i] || hk !== 1'b1) begin
                errors++;
                $display("FAIL directed_%0d n=%h d=%h got lat=%0d res=%h dbz=%b ovf=%b hold=%b exp lat=%0d res=%h dbz=%b ovf=%b hold=1",
                         i, tn[i], td[i], lat, r, dz, ov, hk, elat, tr[i], tz[i], to[i]);
            end
            release_out(i % 2);
        end
    endtask

    task automatic test_backpressure;
        int lat; logic [7:0] r; logic dz, ov, hk; logic stable;
        run_op(8'h07, 8'h03, lat, r, dz, ov, hk);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; numerator = 8'h11; denominator = 8'h00;
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || result !== 8'h25 || divide_by_zero !== 1'b0 || in_ready !== 1'b0)
                stable = 1'b0;
        end
        checks++;
        if (stable !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_hold got stable=%b res=%h exp stable=1 res=25", stable, result);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 8'h25) begin
            errors++;
            $display("FAIL backpressure_release got rdy=%b vld=%b res=%h exp rdy=1 vld=0 res=25", in_ready, out_valid, result);
        end
    endtask

    task automatic test_reset_mid_calc;
        int lat; logic [7:0] r; logic dz, ov, hk;
        in_valid = 1'b1; numerator = 8'h40; denominator = 8'h03;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({in_ready, out_valid, result, divide_by_zero, overflow} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_calc got rdy=%b vld=%b res=%h dbz=%b ovf=%b exp rdy=1 vld=0 res=00 dbz=0 ovf=0",
                     in_ready, out_valid, result, divide_by_zero, overflow);
        end
        run_op(8'hF9, 8'h03, lat, r, dz, ov, hk);
        checks++;
        if (lat !== 13 || r !== 8'hDB || dz !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_op got lat=%0d res=%h dbz=%b exp lat=13 res=db dbz=0", lat, r, dz);
        end
        release_out(0);
    endtask

    task automatic test_random;
        int lat, elat; logic [7:0] n, d, r, er; logic dz, ov, hk, ez, eo;
        for (int i = 0; i < 60; i++) begin
            n = 8'($urandom);
            d = 8'($urandom);
            if ($urandom_range(0, 7) == 0) d = 8'h00;
            if ($urandom_range(0, 9) == 0) n = 8'h80;
            model(n, d, er, ez, eo);
            elat = (d == 8'h00) ? 1 : 13;
            run_op(n, d, lat, r, dz, ov, hk);
            checks++;
            if (lat !== elat || r !== er || dz !== ez || ov !== eo || hk !== 1'b1) begin
                errors++;
                $display("FAIL random_%0d n=%h d=%h got lat=%0d res=%h dbz=%b ovf=%b hold=%b exp lat=%0d res=%h dbz=%b ovf=%b hold=1",
                         i, n, d, lat, r, dz, ov, hk, elat, er, ez, eo);
            end
            release_out($urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_backpressure;
        test_reset_mid_calc;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/div_pf_seq.md
DIV_PF_SEQ -- requirements
Module: div_pf_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1 bit: operand pair offered.
REQ-004 SHALL have port in_ready, output, 1 bit: block can accept an operand pair.
REQ-005 SHALL have port numerator, input, 8 bits signed Q4.4: dividend.
REQ-006 SHALL have port denominator, input, 8 bits signed: divisor.
REQ-007 SHALL have port out_valid, output, 1 bit: result available.
REQ-008 SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-009 SHALL have port result, output, 8 bits: quotient, Q4.4.
REQ-010 SHALL have port divide_by_zero, output, 1 bit: denominator was 0.
REQ-011 SHALL have port overflow, output, 1 bit: quotient outside -128..127 (see Configuration).

Function
REQ-012 SHALL implement FSM states IDLE, CALC and DONE.
REQ-013 SHALL drive in_ready = 1 only in IDLE; accept when in_valid && in_ready at a clock edge, registering both operands.
REQ-014 SHALL, on accept with denominator != 0, enter CALC.
REQ-015 SHALL form ext = numerator sign-extended to 16 bits, shifted left by 4.
REQ-016 SHALL in CALC perform unsigned restoring division of |ext| (12 bits, max 2048) by |denominator| (8 bits, max 128), one quotient bit per cycle, MSB first, for exactly 12 cycles.
REQ-017 SHALL apply the sign to the quotient: negate iff the operand signs differ.
REQ-018 SHALL truncate the quotient toward zero, matching signed integer division ext / denominator.
REQ-019 SHALL move from CALC to DONE on the 12th iteration edge, so out_valid rises 13 edges after the accepting edge.
REQ-020 SHALL, on accept with denominator == 0, skip CALC and enter DONE at the next edge with result = 0x00, divide_by_zero = 1 and overflow = 0; out_valid rises 1 edge after accept.
REQ-021 SHALL hold out_valid, result, divide_by_zero and overflow stable in DONE until out_ready = 1 at an edge, then return to IDLE.
REQ-022 SHALL keep result, divide_by_zero and overflow holding their last values while in IDLE and CALC; they are qualified only by out_valid.
REQ-023 SHALL ignore in_valid, numerator and denominator outside IDLE; there is no queuing of operand pairs.
REQ-024 SHALL handle numerator = -128 (ext = -2048) without internal overflow: 12-bit magnitude, 13-bit signed intermediate.

Reset
REQ-025 SHALL, with rst = 1 at an edge, force state IDLE, in_ready = 1 after the edge, out_valid = 0, result = 0x00, divide_by_zero = 0, overflow = 0, and clear the iteration counter and datapath registers.
REQ-026 SHALL let rst take priority over all other inputs, aborting any CALC or DONE in progress with no result delivered.
REQ-027 SHALL allow an accept on the first edge after rst deasserts.

Configuration
REQ-028 SHALL use the macro DIV_PF_SAT_EN.
REQ-029 SHALL, with DIV_PF_SAT_EN defined, clamp a signed quotient > 127 to 0x7F and one < -128 to 0x80, and set overflow = 1 for that result.
REQ-030 SHALL, with DIV_PF_SAT_EN undefined, output the low 8 bits of the signed quotient (wrap-around) and tie overflow to 0.

Verification
REQ-031 SHALL cover num=0x08, den=0x04 -> result 0x20, dbz=0, out_valid 13 edges after accept.
REQ-032 SHALL cover num=0xF9 (-7), den=0x03 -> result 0xDB (-37, truncated toward zero); num=0x07, den=0x03 -> result 0x25.
REQ-033 SHALL cover num=0x20, den=0x04 -> quotient 128: with DIV_PF_SAT_EN result 0x7F, ovf=1; without it result 0x80, ovf=0. Also num=0x80, den=0x01 -> with DIV_PF_SAT_EN result 0x80, ovf=1; without it result 0x00.
REQ-034 SHALL cover num=0x35, den=0x00 -> result 0x00, dbz=1, out_valid 1 edge after accept.
REQ-035 SHALL cover out_ready held low for 5 cycles in DONE -> outputs stable and in_ready=0 throughout; return to IDLE on the edge where out_ready=1.
REQ-036 SHALL cover rst asserted at CALC iteration 6 -> IDLE, out_valid=0, all outputs 0 next edge; a following operation computes correctly.
